cart_ram: RTL
=============

# cart_ram

Cartridge RAM store directly downstream of the mapper block. It consumes the mapper's banked RAM address, RAM enable and direct-write strobe, together with CPU bus writes, and returns read data to the mapper as `cram_di`. A second, independent 16-bit port carries save-file load and dump traffic between the host and battery RAM. The block also keeps a dirty flag that drives autosave.

## Interface
- `ADDR_W`, default 17: byte address width (128 KiB).
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ce_cpu` in 1: CPU clock enable (already speed-selected).
- `has_ram` in 1: cartridge declares RAM. When low, all cart-side writes are suppressed.
- `ram_mask` in 4: bank mask applied to byte address bits [16:13].
- `cart_addr` in 16: CPU bus address.
- `cart_wr` in 1: CPU write strobe.
- `cart_di` in 8: CPU write data.
- `ram_enabled` in 1: mapper RAM enable.
- `cram_addr` in 17: mapper banked RAM byte address.
- `cram_wr` in 1: mapper direct write (MBC7 EEPROM).
- `cram_wr_do` in 8: mapper direct write data.
- `cram_di` out 8: registered read data to the mapper.
- `bk_addr` in 17: save-file word address. Bit 16 is ignored; the word covers byte addresses 2·a and 2·a+1.
- `bk_wr` in 1: save word write request, one-clock pulse.
- `bk_data` in 16: save write data. The low byte goes to the even address.
- `bk_rd` in 1: save word read request, one-clock pulse.
- `bk_q` out 16: save read data.
- `bk_ack` out 1: one-clock pulse when `bk_q` is valid.
- `bk_busy` out 1: save port sequencing.
- `dirty` out 1: RAM modified since the last clear.
- `dirty_clr` in 1: clears `dirty`.

## Operation

**Storage and addressing**
- Storage is a true dual-port 2^ADDR_W×8 RAM: port A serves the cart side, port B serves the save port.
- Reset does not clear RAM contents.
- Masked address: `ma = {addr[16:13] & ram_mask, addr[12:0]}`. Both ports use it.

**Port A**
- Port A reads `ma(cram_addr)` every clock.
- Port A write sources, in priority order:
  1. `cram_wr` writes `cram_wr_do`.
  2. CPU write, which requires `ce_cpu & cart_wr & cart_addr[15:13]==3'b101 & ram_enabled`, writes `cart_di`.
- Both sources require `has_ram=1`.
- When both are active in the same cycle, the mapper write wins and the CPU write is dropped.
- Write address is `ma(cram_addr)` for both sources.

**Dirty flag**
- `dirty` sets on any port-A write that takes effect.
- `dirty_clr` clears it.
- A write in the same cycle as `dirty_clr` leaves `dirty=1`.
- Save-port writes never set `dirty`.

**Save-port FSM (port B)**
States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_DONE.
- IDLE:
  - `bk_wr` latches address and data, then goes to WR_LO.
  - Otherwise `bk_rd` latches address, then goes to RD_LO.
  - `bk_wr` and `bk_rd` together: write wins, the read is discarded.
- WR_LO: writes the low byte to 2a, then goes to WR_HI.
- WR_HI: writes the high byte to 2a+1, then goes to IDLE.
- RD_LO: issues read of 2a, then goes to RD_HI.
- RD_HI: issues read of 2a+1, captures the low byte, then goes to RD_DONE.
- RD_DONE: captures the high byte, loads `bk_q`, pulses `bk_ack`, then goes to IDLE.
- `bk_busy = (state != IDLE)`.
- New `bk_wr`/`bk_rd` while busy is ignored. The requester must wait for `bk_busy=0`.
- **Collision:** a port-A write takes effect in the same cycle that WR_LO or WR_HI targets the same masked byte.
  - Port A wins.
  - The port-B write is not issued that cycle and the FSM holds its state. It retries the next cycle.
  - Reads never stall.

## Timing
- `cram_di` is valid 1 clock after `cram_addr` is presented.
- A port-A write is visible on `cram_di` the clock after the write cycle, with the address held.
- Save write, `bk_wr` sampled at clock 0:
  - Low byte written at clock 1, high byte at clock 2.
  - `bk_busy` is high in clocks 1–2 and low from clock 3.
  - Each collision stall adds 1 clock.
- Save read, `bk_rd` sampled at clock 0:
  - `bk_busy` is high in clocks 1–3.
  - `bk_ack` is high in clock 4 only, with `bk_q` updated in the same clock.
  - `bk_q` holds until the next read completes.
- Back-to-back throughput is one word per 3 clocks (write) or 4 clocks (read): the next request is accepted in the first clock with `bk_busy=0`.
- Reset values:
  - `cram_di=8'hFF`
  - `bk_q=16'h0000`
  - `bk_ack=0`
  - `bk_busy=0`
  - `dirty=0`
  - FSM in IDLE
- Reset in mid-sequence aborts the sequence: a pending high byte is not written and no `bk_ack` is issued.

## Test plan
- **CPU write / read:** `ram_mask=4'h3`, `ram_enabled=1`, `has_ram=1`, CPU writes 0x5A at A123 with `cram_addr=0x02123` → `cram_di=0x5A` one clock after the read address is presented; `dirty=1`. Repeat with `ram_enabled=0` → RAM unchanged, `dirty` stays 0.
- **Mask alias:** `ram_mask=4'h1`, write 0x77 via `cram_addr=0x06000` → read at `cram_addr=0x02000` returns 0x77.
- **Save write then read:** `bk_wr` with `bk_addr=0x0010`, `bk_data=0xBEEF` → byte 0x20=0xEF and 0x21=0xBE; `bk_busy` high for exactly 2 clocks. Then `bk_rd` at 0x0010 → `bk_ack` 4 clocks later with `bk_q=0xBEEF`.
- **Collision:** during WR_HI to byte 0x21, inject `cram_wr` to `cram_addr=0x00021` with 0x11 → `bk_busy` high for 3 clocks total; final byte is 0xBE (port-B retry lands last).
- **Priority and dirty:** `cram_wr` and CPU write in the same cycle → only `cram_wr_do` is stored. Write and `dirty_clr` in the same cycle → `dirty=1`. `dirty_clr` alone → `dirty=0`.
- **Reset mid-operation:** assert `reset` in RD_HI → no `bk_ack`, `bk_busy=0`, `cram_di=0xFF` next clock; previously written RAM contents are preserved.

Source files
------------

// File: rtl/cart_ram.sv
// cart_ram: cartridge RAM store sitting behind the mapper.
//   Port A (cart side): mapper banked address, mapper direct write, CPU bus
//   write; registered read data back to the mapper on cram_di.
//   Port B (save side): 16-bit word load/dump sequenced by a small FSM.
// Ports:
//   clk_sys, reset        system clock, synchronous active-high reset
//   ce_cpu, cart_*        CPU bus write path (gated by ram_enabled)
//   has_ram, ram_mask     cart RAM present, bank mask on byte addr [16:13]
//   cram_addr/wr/wr_do    mapper banked address and direct write
//   cram_di               registered port-A read data
//   bk_*                  save-file word port (request, data, ack, busy)
//   dirty, dirty_clr      RAM-modified flag for autosave
module cart_ram #(
    parameter int ADDR_W = 17
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_cpu,
    input  logic        has_ram,
    input  logic [3:0]  ram_mask,
    input  logic [15:0] cart_addr,
    input  logic        cart_wr,
    input  logic [7:0]  cart_di,
    input  logic        ram_enabled,
    input  logic [16:0] cram_addr,
    input  logic        cram_wr,
    input  logic [7:0]  cram_wr_do,
    output logic [7:0]  cram_di,
    input  logic [16:0] bk_addr,
    input  logic        bk_wr,
    input  logic [15:0] bk_data,
    input  logic        bk_rd,
    output logic [15:0] bk_q,
    output logic        bk_ack,
    output logic        bk_busy,
    output logic        dirty,
    input  logic        dirty_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_RD_LO,
        S_RD_HI,
        S_RD_DONE
    } state_t;

    function automatic logic [16:0] f_mask(input logic [16:0] a, input logic [3:0] m);
        return {a[16:13] & m, a[12:0]};
    endfunction

    logic [7:0]  r_mem [0:(2**ADDR_W)-1];

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_bk_addr;
    logic [15:0] r_bk_data;
    logic [7:0]  r_b_rd;
    logic [7:0]  r_rd_lo;
    logic [7:0]  r_cram_di;
    logic [15:0] r_bk_q;
    logic        r_bk_ack;
    logic        r_dirty;

    logic [16:0] w_a_ma;
    logic [16:0] w_b_ma;
    logic        w_cpu_we;
    logic        w_a_we;
    logic [7:0]  w_a_wdata;
    logic        w_b_hi;
    logic        w_b_we;
    logic [7:0]  w_b_wdata;
    logic        w_collide;
    logic        w_unused;

    // Save words always start on an even byte; bit 16 of the word address
    // would fall outside the 128 KiB byte space.
    assign w_unused = bk_addr[16];

    assign w_a_ma    = f_mask(cram_addr, ram_mask);
    assign w_b_hi    = (r_state == S_WR_HI) || (r_state == S_RD_HI);
    assign w_b_ma    = f_mask({r_bk_addr, w_b_hi}, ram_mask);

    assign w_cpu_we  = ce_cpu && cart_wr && (cart_addr[15:13] == 3'b101) && ram_enabled;
    assign w_a_we    = has_ram && (cram_wr || w_cpu_we);
    assign w_a_wdata = cram_wr ? cram_wr_do : cart_di;

    // Port A owns a byte when both ports write it in the same cycle; the save
    // FSM stalls in place and retries so its data lands last.
    assign w_collide = w_a_we && (w_a_ma == w_b_ma);

    always_comb begin
        w_state_nxt = r_state;
        w_b_we      = 1'b0;
        w_b_wdata   = r_bk_data[7:0];
        unique case (r_state)
            S_IDLE: begin
                if (bk_wr)
                    w_state_nxt = S_WR_LO;
                else if (bk_rd)
                    w_state_nxt = S_RD_LO;
            end
            S_WR_LO: begin
                if (!w_collide) begin
                    w_b_we      = 1'b1;
                    w_state_nxt = S_WR_HI;
                end
            end
            S_WR_HI: begin
                w_b_wdata = r_bk_data[15:8];
                if (!w_collide) begin
                    w_b_we      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_LO:   w_state_nxt = S_RD_HI;
            S_RD_HI:   w_state_nxt = S_RD_DONE;
            S_RD_DONE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_sys) begin
        if (r_state == S_IDLE && (bk_wr || bk_rd))
            r_bk_addr <= bk_addr[15:0];
        if (r_state == S_IDLE && bk_wr)
            r_bk_data <= bk_data;
    end

    // Both ports write from one process; the collision stall guarantees they
    // never target the same byte in the same cycle. Reset blocks a pending
    // save-port byte so an aborted sequence leaves memory untouched.
    always_ff @(posedge clk_sys) begin
        if (w_b_we && !reset)
            r_mem[w_b_ma[ADDR_W-1:0]] <= w_b_wdata;
        if (w_a_we)
            r_mem[w_a_ma[ADDR_W-1:0]] <= w_a_wdata;
    end

    always_ff @(posedge clk_sys) begin
        r_b_rd <= r_mem[w_b_ma[ADDR_W-1:0]];
        if (r_state == S_RD_HI)
            r_rd_lo <= r_b_rd;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cram_di <= 8'hFF;
            r_bk_q    <= '0;
            r_bk_ack  <= 1'b0;
            r_dirty   <= 1'b0;
        end else begin
            r_cram_di <= r_mem[w_a_ma[ADDR_W-1:0]];
            r_bk_ack  <= (r_state == S_RD_DONE);
            if (r_state == S_RD_DONE)
                r_bk_q <= {r_b_rd, r_rd_lo};
            if (w_a_we)
                r_dirty <= 1'b1;
            else if (dirty_clr)
                r_dirty <= 1'b0;
        end
    end

    assign cram_di = r_cram_di;
    assign bk_q    = r_bk_q;
    assign bk_ack  = r_bk_ack;
    assign bk_busy = (r_state != S_IDLE);
    assign dirty   = r_dirty;

endmodule
